// File: rtl/pipelined_addsub.sv
// Pipelined WIDTH-bit two's-complement adder/subtractor with valid/ready handshakes.
// Define ADDSUB_SATURATE_EN to clamp the result to the signed range on overflow.

module pipelined_addsub_slice #(
    parameter int SEG = 4
) (
    input  logic [SEG-1:0] a,
    input  logic [SEG-1:0] b,
    input  logic           ci,
    output logic [SEG-1:0] s,
    output logic           co
);
    assign {co, s} = {1'b0, a} + {1'b0, b} + {{SEG{1'b0}}, ci};
endmodule

module pipelined_addsub #(
    parameter int WIDTH  = 16,
    parameter int STAGES = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);
    localparam int SEG = WIDTH / STAGES;

    if ((STAGES < 1) || (STAGES > WIDTH) || ((WIDTH % STAGES) != 0)) begin : g_bad_cfg
        $error("pipelined_addsub: WIDTH must be a non-zero multiple of STAGES");
    end

    logic              adv;
    logic [WIDTH-1:0]  b_eff;
    logic              c0;
    logic [STAGES-1:0] vld_d, vld_q;
    logic [WIDTH-1:0]  sum_d, sum_q;
    logic              cout_d, cout_q;
    logic              ovf_d, ovf_q;

    always_comb begin
        adv   = ~vld_q[STAGES-1] | out_ready;
        b_eff = sub ? ~b : b;
        c0    = cin ^ sub;
        vld_d = (vld_q << 1) | STAGES'(in_valid);
    end

    assign in_ready  = adv;
    assign out_valid = vld_q[STAGES-1];
    assign sum       = sum_q;
    assign cout      = cout_q;
    assign ovf       = ovf_q;

    // Stage k consumes operand slice k; ua/ub hold the still-pending upper bits
    // shifted down so the slice to add always sits at [SEG-1:0].
    for (genvar k = 0; k < STAGES; k++) begin : g_stg
        localparam int LO = k * SEG;
        localparam int HI = LO + SEG;

        logic [WIDTH-LO-1:0] ua, ub;
        logic                ci;
        logic [SEG-1:0]      ss;
        logic                co;
        logic [HI-1:0]       lo;

        pipelined_addsub_slice #(.SEG(SEG)) u_slice (
            .a  (ua[SEG-1:0]),
            .b  (ub[SEG-1:0]),
            .ci (ci),
            .s  (ss),
            .co (co)
        );

        if (k == 0) begin : g_in
            assign ua = a;
            assign ub = b_eff;
            assign ci = c0;
            assign lo = ss;
        end else begin : g_in
            assign ua = g_stg[k-1].g_reg.ua_q;
            assign ub = g_stg[k-1].g_reg.ub_q;
            assign ci = g_stg[k-1].g_reg.c_q;
            assign lo = {ss, g_stg[k-1].g_reg.lo_q};
        end

        if (k < STAGES - 1) begin : g_reg
            logic [WIDTH-HI-1:0] ua_d, ua_q, ub_d, ub_q;
            logic [HI-1:0]       lo_d, lo_q;
            logic                c_d, c_q;

            always_comb begin
                ua_d = ua[WIDTH-LO-1:SEG];
                ub_d = ub[WIDTH-LO-1:SEG];
                lo_d = lo;
                c_d  = co;
            end

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    ua_q <= '0;
                    ub_q <= '0;
                    lo_q <= '0;
                    c_q  <= 1'b0;
                end else if (adv) begin
                    ua_q <= ua_d;
                    ub_q <= ub_d;
                    lo_q <= lo_d;
                    c_q  <= c_d;
                end
            end
        end else begin : g_out
            // The top slice still carries the beat's own A and B_eff sign bits.
            always_comb begin
                sum_d  = lo;
                cout_d = co;
                ovf_d  = (ua[SEG-1] == ub[SEG-1]) && (ss[SEG-1] != ua[SEG-1]);
`ifdef ADDSUB_SATURATE_EN
                if (ovf_d) begin
                    sum_d = ua[SEG-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
                end
`endif
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_q  <= '0;
            sum_q  <= '0;
            cout_q <= 1'b0;
            ovf_q  <= 1'b0;
        end else if (adv) begin
            vld_q  <= vld_d;
            sum_q  <= sum_d;
            cout_q <= cout_d;
            ovf_q  <= ovf_d;
        end
    end
endmodule

// File: tb/tb_pipelined_addsub.sv
// Scoreboard bench for pipelined_addsub: integer reference model, random traffic,
// backpressure, stall, reset-in-flight and latency checks.

module tb_pipelined_addsub;
    localparam int W  = 16;
    localparam int ST = 4;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         cin = 1'b0;
    logic         sub = 1'b0;
    logic         out_valid;
    logic         out_ready = 1'b1;
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;

    typedef struct packed {
        logic [W-1:0] sum;
        logic         cout;
        logic         ovf;
    } exp_t;

    exp_t exp_q[$];
    int   tests = 0;
    int   fails = 0;
    int   cyc = 0;
    int   acc_cyc = 0;

    pipelined_addsub #(.WIDTH(W), .STAGES(ST)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .sub       (sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .ovf       (ovf)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        tests++;
        if (got !== want) begin
            fails++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, got, want, $time);
        end
    endtask

    // Reference: true mathematical results, then reduced to the port view.
    function automatic exp_t model(input logic [W-1:0] ta, input logic [W-1:0] tbv,
                                   input logic tc, input logic ts);
        int          ua, ub, sa, sb, ur, sr, smax, smin;
        logic [31:0] r;
        exp_t        e;
        ua   = int'(ta);
        ub   = int'(tbv);
        sa   = int'($signed(ta));
        sb   = int'($signed(tbv));
        ur   = ts ? (ua - ub - int'(tc)) : (ua + ub + int'(tc));
        sr   = ts ? (sa - sb - int'(tc)) : (sa + sb + int'(tc));
        smax = (1 << (W - 1)) - 1;
        smin = -(1 << (W - 1));
        r    = ur;
        e.sum  = r[W-1:0];
        e.cout = ts ? ((ur >= 0) ? 1'b1 : 1'b0) : ((ur >= (1 << W)) ? 1'b1 : 1'b0);
        e.ovf  = ((sr > smax) || (sr < smin)) ? 1'b1 : 1'b0;
`ifdef ADDSUB_SATURATE_EN
        if (sr > smax) e.sum = {1'b0, {(W-1){1'b1}}};
        else if (sr < smin) e.sum = {1'b1, {(W-1){1'b0}}};
`endif
        return e;
    endfunction

    function automatic logic [W-1:0] pick();
        case ($urandom_range(0, 5))
            0: return '0;
            1: return '1;
            2: return {1'b0, {(W-1){1'b1}}};
            3: return {1'b1, {(W-1){1'b0}}};
            default: return W'($urandom);
        endcase
    endfunction

    task automatic send(input logic [W-1:0] ta, input logic [W-1:0] tbv,
                        input logic tc, input logic ts);
        bit ok = 1'b0;
        @(posedge clk); #1;
        in_valid = 1'b1; a = ta; b = tbv; cin = tc; sub = ts;
        for (int n = 0; n < 200 && !ok; n++) begin
            @(negedge clk);
            if (in_ready) begin
                exp_q.push_back(model(ta, tbv, tc, ts));
                acc_cyc = cyc;
                ok = 1'b1;
            end else begin
                @(posedge clk); #1;
            end
        end
        check("accept", 32'(ok), 32'd1);
    endtask

    task automatic idle();
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        for (int n = 0; n < 300 && exp_q.size() != 0; n++) @(negedge clk);
        check("drain", 32'(exp_q.size()), 32'd0);
    endtask

    task automatic latency_check(input string name);
        int t = acc_cyc;
        for (int n = 0; n < 20 && !out_valid; n++) @(negedge clk);
        check(name, 32'(cyc - t), 32'(ST));
    endtask

    // Whatever the DUT presents must be the oldest outstanding beat, stalled or not.
    always @(negedge clk) begin
        if (!rst && out_valid) begin
            if (exp_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_out: got sum=0x%0h with no beat outstanding", sum);
            end else begin
                check("out", 32'({sum, cout, ovf}), 32'(exp_q[0]));
                if (out_ready) void'(exp_q.pop_front());
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, %0d beats outstanding", exp_q.size());
        $fatal(1, "watchdog");
    end

    initial begin
        int t0;
        repeat (3) @(negedge clk);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_sum", 32'(sum), 32'd0);
        check("rst_cout_ovf", 32'({cout, ovf}), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_in_ready", 32'(in_ready), 32'd1);
        check("post_rst_out_valid", 32'(out_valid), 32'd0);

        // Directed corner beats
        send(16'h1234, 16'h4321, 1'b0, 1'b0);
        idle();
        latency_check("latency_first");
        send(16'hFFFF, 16'h0001, 1'b0, 1'b0);
        send(16'h7FFF, 16'h0001, 1'b0, 1'b0);
        send(16'h8000, 16'h0001, 1'b0, 1'b1);
        send(16'h0003, 16'h0005, 1'b0, 1'b1);
        send(16'hFFFF, 16'hFFFF, 1'b1, 1'b0);
        send(16'h0000, 16'h0000, 1'b1, 1'b1);
        send(16'h0000, 16'h8000, 1'b0, 1'b1);
        send(16'h8000, 16'h8000, 1'b0, 1'b0);
        idle();
        drain();

        // 10 back-to-back beats with a 3-cycle output stall in the middle
        fork
            begin
                send(pick(), pick(), 1'($urandom), 1'($urandom));
                t0 = acc_cyc;
                for (int i = 1; i < 10; i++) send(pick(), pick(), 1'($urandom), 1'($urandom));
                check("stream_throughput", 32'(acc_cyc - t0), 32'd12);
                idle();
            end
            begin
                repeat (6) @(posedge clk);
                #1 out_ready = 1'b0;
                repeat (3) begin
                    @(negedge clk);
                    check("stall_in_ready", 32'(in_ready), 32'd0);
                    check("stall_out_valid", 32'(out_valid), 32'd1);
                    @(posedge clk);
                end
                #1 out_ready = 1'b1;
            end
        join
        drain();

        // Reset with 3 beats in flight
        send(16'h1111, 16'h2222, 1'b0, 1'b0);
        send(16'h3333, 16'h0001, 1'b1, 1'b1);
        send(16'hABCD, 16'h1234, 1'b0, 1'b0);
        idle();
        #2 rst = 1'b1;
        #1;
        check("midrst_out_valid", 32'(out_valid), 32'd0);
        check("midrst_sum", 32'(sum), 32'd0);
        exp_q.delete();
        repeat (2) @(posedge clk);
        @(negedge clk) rst = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            check("no_stale_beat", 32'(out_valid), 32'd0);
        end
        check("midrst_in_ready", 32'(in_ready), 32'd1);
        send(16'h0F0F, 16'h00F1, 1'b0, 1'b0);
        idle();
        latency_check("latency_after_rst");
        drain();

        // Random traffic with input bubbles and random backpressure
        fork
            begin
                for (int i = 0; i < 200; i++) begin
                    if ($urandom_range(0, 3) == 0) idle();
                    send(pick(), pick(), 1'($urandom), 1'($urandom));
                end
                idle();
            end
            begin
                repeat (300) begin
                    @(posedge clk); #1;
                    out_ready = ($urandom_range(0, 3) != 0);
                end
                out_ready = 1'b1;
            end
        join
        out_ready = 1'b1;
        drain();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
